// File: rtl/dmem_responder.sv
// Data-memory responder: captures one request, waits LATENCY cycles, pulses mem_resp.
// Optional macro DMEM_RANGE_CHECK_EN flags and suppresses accesses above the array.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam int         LOAD_INT = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [3:0] LOAD_VAL = 4'(LOAD_INT);
  localparam bit         HAS_WAIT = (LATENCY > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [3:0]              cnt_r;
  logic [3:0]              cnt_next_s;
  logic                    accept_s;
  logic                    req_s;
  logic                    oor_s;
  logic [ADDR_WIDTH-1:0]   idx_s;
  logic [ADDR_WIDTH-1:0]   idx_r;
  logic [1:0]              be_r;
  logic [15:0]             wdata_r;
  logic                    write_r;
  logic                    oor_r;
  logic                    entering_resp_s;
  logic                    resp_write_s;
  logic                    resp_oor_s;
  logic [ADDR_WIDTH-1:0]   resp_idx_s;
  logic [15:0]             mem_rdata_r;
  logic                    mem_resp_r;
  logic                    mem_err_r;
  logic                    unused_addr_s;
  logic [15:0]             mem_r [DEPTH];

  // Replace only the enabled byte lanes of a stored word.
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_word,
                                              input logic [15:0] new_word,
                                              input logic [1:0]  be);
    logic [15:0] result;
    result[7:0]  = be[0] ? new_word[7:0]  : old_word[7:0];
    result[15:8] = be[1] ? new_word[15:8] : old_word[15:8];
    return result;
  endfunction

  assign req_s = mem_read | mem_write;
  assign idx_s = mem_address[ADDR_WIDTH:1];

`ifdef DMEM_RANGE_CHECK_EN
  assign oor_s = (mem_address >> (ADDR_WIDTH + 1)) != 16'd0;
`else
  assign oor_s = 1'b0;
`endif

  // Byte-select bit and (by default) the aliased upper bits carry no meaning here.
  assign unused_addr_s = ^{mem_address[0], mem_address >> (ADDR_WIDTH + 1)};

  // Next-state and counter logic for IDLE -> BUSY -> RESP -> IDLE.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          accept_s   = 1'b1;
          cnt_next_s = LOAD_VAL;
          if (HAS_WAIT) begin
            next_state_s = BUSY;
          end else begin
            next_state_s = RESP;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          next_state_s = RESP;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // With zero latency the response is computed from the live request, not the capture.
  assign entering_resp_s = (next_state_s == RESP);
  assign resp_write_s    = accept_s ? mem_write : write_r;
  assign resp_oor_s      = accept_s ? oor_s     : oor_r;
  assign resp_idx_s      = accept_s ? idx_s     : idx_r;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Request capture on acceptance; held untouched until the next acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r   <= '0;
      be_r    <= 2'b00;
      wdata_r <= 16'h0000;
      write_r <= 1'b0;
      oor_r   <= 1'b0;
    end else if (accept_s) begin
      idx_r   <= idx_s;
      be_r    <= mem_byte_enable;
      wdata_r <= mem_wdata;
      write_r <= mem_write;
      oor_r   <= oor_s;
    end
  end

  // Registered response outputs; read data only moves on a read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_resp_r  <= 1'b0;
      mem_rdata_r <= 16'h0000;
      mem_err_r   <= 1'b0;
    end else begin
      mem_resp_r <= entering_resp_s;
      if (entering_resp_s && !resp_write_s) begin
        mem_rdata_r <= resp_oor_s ? 16'h0000 : mem_r[resp_idx_s];
      end
      if (entering_resp_s && resp_oor_s) begin
        mem_err_r <= 1'b1;
      end
    end
  end

  // Writes commit at the edge that closes RESP, so a reset before then drops them.
  always_ff @(posedge clk) begin
    if (state_r == RESP && write_r && !oor_r && be_r != 2'b00) begin
      mem_r[idx_r] <= merge_lanes(mem_r[idx_r], wdata_r, be_r);
    end
  end

  assign mem_rdata = mem_rdata_r;
  assign mem_resp  = mem_resp_r;
  assign mem_err   = mem_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// checked against an array model of the memory and the latency rule.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  logic [15:0] z_address;
  logic        z_read;
  logic        z_write;
  logic [1:0]  z_be;
  logic [15:0] z_wdata;
  logic [15:0] z_rdata;
  logic        z_resp;
  logic        z_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_mem [0:1023];
  logic [15:0] ref_rdata;
  logic        ref_err;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_err(mem_err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .mem_address(z_address), .mem_read(z_read),
    .mem_write(z_write), .mem_byte_enable(z_be), .mem_wdata(z_wdata),
    .mem_rdata(z_rdata), .mem_resp(z_resp), .mem_err(z_err)
  );

  function automatic bit out_of_range(input logic [15:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a[15:11] != 5'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Memory model: what one completed request does to the array and the read port.
  task automatic model_apply(input bit wr, input logic [15:0] a, input logic [1:0] be,
                             input logic [15:0] wd);
    int w;
    w = int'(a[10:1]);
    if (out_of_range(a)) begin
      ref_err = 1'b1;
      if (!wr) ref_rdata = 16'h0000;
    end else if (wr) begin
      if (be[0]) ref_mem[w][7:0]  = wd[7:0];
      if (be[1]) ref_mem[w][15:8] = wd[15:8];
    end else begin
      ref_rdata = ref_mem[w];
    end
  endtask

  // Drive one request from an IDLE negedge; report latency, read data and the gap cycle.
  task automatic xfer(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [1:0] be, input logic [15:0] wd,
                      output int lat, output logic [15:0] rdata,
                      output logic err, output logic resp_after);
    mem_read = rd; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        lat = k;
        break;
      end
    end
    rdata = mem_rdata;
    err   = mem_err;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp_after = mem_resp;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0000;
    mem_byte_enable = 2'b00; mem_wdata = 16'h0000;
    z_read = 1'b0; z_write = 1'b0; z_address = 16'h0000; z_be = 2'b00; z_wdata = 16'h0000;
    ref_rdata = 16'h0000; ref_err = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_resp, mem_rdata, mem_err} !== {1'b0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got resp=%b rdata=%h err=%b exp 0/0000/0", mem_resp, mem_rdata, mem_err);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (mem_resp !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_resp got=%b exp=0", mem_resp);
    end
  endtask

  task automatic test_basic();
    int lat; logic [15:0] rd; logic err; logic ra;
    xfer(1'b0, 1'b1, 16'h0010, 2'b11, 16'hBEEF, lat, rd, err, ra);
    model_apply(1'b1, 16'h0010, 2'b11, 16'hBEEF);
    total++;
    if (lat !== LAT + 1) begin bad++; $display("FAIL basic_wr_latency got=%0d exp=%0d", lat, LAT + 1); end
    total++;
    if (ra !== 1'b0) begin bad++; $display("FAIL basic_wr_single_pulse got=%b exp=0", ra); end
    xfer(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, rd, err, ra);
    model_apply(1'b0, 16'h0010, 2'b00, 16'h0000);
    total++;
    if (lat !== LAT + 1) begin bad++; $display("FAIL basic_rd_latency got=%0d exp=%0d", lat, LAT + 1); end
    total++;
    if (rd !== 16'hBEEF) begin bad++; $display("FAIL basic_rd_data got=%h exp=beef", rd); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [15:0] rd; logic err; logic ra;
    xfer(1'b0, 1'b1, 16'h0020, 2'b11, 16'h1234, lat, rd, err, ra);
    xfer(1'b0, 1'b1, 16'h0020, 2'b10, 16'hAB00, lat, rd, err, ra);
    xfer(1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, lat, rd, err, ra);
    total++;
    if (rd !== 16'hAB34) begin bad++; $display("FAIL lanes_upper got=%h exp=ab34", rd); end
    xfer(1'b0, 1'b1, 16'h0020, 2'b00, 16'h5A5A, lat, rd, err, ra);
    total++;
    if (lat !== LAT + 1) begin bad++; $display("FAIL lanes_be00_latency got=%0d exp=%0d", lat, LAT + 1); end
    total++;
    if (rd !== 16'hAB34) begin bad++; $display("FAIL lanes_rdata_hold got=%h exp=ab34", rd); end
    xfer(1'b1, 1'b0, 16'h0021, 2'b00, 16'h0000, lat, rd, err, ra);
    total++;
    if (rd !== 16'hAB34) begin bad++; $display("FAIL lanes_be00 got=%h exp=ab34", rd); end
    xfer(1'b0, 1'b1, 16'h0020, 2'b01, 16'hFFCD, lat, rd, err, ra);
    xfer(1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, lat, rd, err, ra);
    total++;
    if (rd !== 16'hABCD) begin bad++; $display("FAIL lanes_lower got=%h exp=abcd", rd); end
    ref_mem[16] = 16'hABCD;
    ref_rdata = 16'hABCD;
  endtask

  task automatic test_priority();
    int lat; logic [15:0] rd; logic err; logic ra;
    xfer(1'b1, 1'b1, 16'h0022, 2'b11, 16'h7777, lat, rd, err, ra);
    total++;
    if (rd !== 16'hABCD) begin bad++; $display("FAIL prio_rdata_hold got=%h exp=abcd", rd); end
    xfer(1'b1, 1'b0, 16'h0022, 2'b00, 16'h0000, lat, rd, err, ra);
    total++;
    if (rd !== 16'h7777) begin bad++; $display("FAIL prio_write_wins got=%h exp=7777", rd); end
    ref_mem[17] = 16'h7777;
    ref_rdata = 16'h7777;
  endtask

  task automatic test_indirect();
    int lat; int lat1; int lat2; logic [15:0] rd; logic [15:0] rd1; logic err; logic ra; logic gap;
    xfer(1'b0, 1'b1, 16'h0030, 2'b11, 16'h0040, lat, rd, err, ra);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h0030;
    @(posedge clk);
    lat1 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin lat1 = k; break; end
    end
    rd1 = mem_rdata;
    mem_read = 1'b0; mem_write = 1'b1; mem_address = rd1; mem_byte_enable = 2'b11; mem_wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    gap = mem_resp;
    lat2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin lat2 = k; break; end
    end
    rd = mem_rdata;
    mem_write = 1'b0;
    @(posedge clk); @(negedge clk);
    ra = mem_resp;
    total++;
    if (lat1 !== LAT + 1) begin bad++; $display("FAIL ind_rd_latency got=%0d exp=%0d", lat1, LAT + 1); end
    total++;
    if (rd1 !== 16'h0040) begin bad++; $display("FAIL ind_pointer got=%h exp=0040", rd1); end
    total++;
    if (gap !== 1'b0) begin bad++; $display("FAIL ind_gap got=%b exp=0", gap); end
    total++;
    if (lat2 !== LAT + 1) begin bad++; $display("FAIL ind_wr_spacing got=%0d exp=%0d", lat2 + 1, LAT + 2); end
    total++;
    if ({rd, ra} !== {16'h0040, 1'b0}) begin bad++; $display("FAIL ind_wr_resp got rdata=%h after=%b exp 0040/0", rd, ra); end
    xfer(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, lat, rd, err, ra);
    total++;
    if (rd !== 16'h5555) begin bad++; $display("FAIL ind_result got=%h exp=5555", rd); end
    ref_mem[24] = 16'h0040; ref_mem[32] = 16'h5555; ref_rdata = 16'h5555;
  endtask

  task automatic test_captured();
    int lat; logic [15:0] rd; logic err; logic ra;
    mem_read = 1'b0; mem_write = 1'b1; mem_address = 16'h0024; mem_byte_enable = 2'b11; mem_wdata = 16'h4242;
    @(posedge clk);
    #1;
    mem_write = 1'b0; mem_address = 16'h0026; mem_wdata = 16'h0000; mem_byte_enable = 2'b00;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin lat = k; break; end
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (lat !== LAT + 1) begin bad++; $display("FAIL captured_latency got=%0d exp=%0d", lat, LAT + 1); end
    xfer(1'b1, 1'b0, 16'h0024, 2'b00, 16'h0000, lat, rd, err, ra);
    total++;
    if (rd !== 16'h4242) begin bad++; $display("FAIL captured_data got=%h exp=4242", rd); end
    ref_mem[18] = 16'h4242; ref_rdata = 16'h4242;
  endtask

  task automatic test_back_to_back();
    logic prev; int seen_bad; int rd_bad;
    z_read = 1'b0; z_write = 1'b1; z_address = 16'h0010; z_be = 2'b11; z_wdata = 16'h6161;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (z_resp === 1'b1) break;
    end
    z_write = 1'b0;
    @(posedge clk); @(negedge clk);
    z_read = 1'b1;
    prev = 1'b0; seen_bad = 0; rd_bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (z_resp !== ((k % 2) == 1)) seen_bad++;
      if (prev && z_resp) seen_bad++;
      if (z_resp && z_rdata !== 16'h6161) rd_bad++;
      prev = z_resp;
    end
    z_read = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (seen_bad !== 0) begin bad++; $display("FAIL lat0_pattern got=%0d bad cycles exp=0", seen_bad); end
    total++;
    if (rd_bad !== 0) begin bad++; $display("FAIL lat0_rdata got=%0d bad reads exp=0", rd_bad); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] rd; logic err; logic ra; int seen;
    xfer(1'b0, 1'b1, 16'h0050, 2'b11, 16'h0A0A, lat, rd, err, ra);
    xfer(1'b1, 1'b0, 16'h0050, 2'b00, 16'h0000, lat, rd, err, ra);
    mem_write = 1'b1; mem_address = 16'h0050; mem_byte_enable = 2'b11; mem_wdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({mem_resp, mem_rdata, mem_err} !== {1'b0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL midreset_outputs got resp=%b rdata=%h err=%b exp 0/0000/0", mem_resp, mem_rdata, mem_err);
    end
    mem_write = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_resp !== 1'b0) seen++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_resp !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midreset_no_resp got=%0d pulses exp=0", seen); end
    xfer(1'b1, 1'b0, 16'h0050, 2'b00, 16'h0000, lat, rd, err, ra);
    total++;
    if (rd !== 16'h0A0A) begin bad++; $display("FAIL midreset_no_commit got=%h exp=0a0a", rd); end
    ref_mem[40] = 16'h0A0A; ref_rdata = 16'h0A0A; ref_err = 1'b0;
  endtask

  task automatic test_range();
    int lat; logic [15:0] rd; logic err; logic ra;
    xfer(1'b0, 1'b1, 16'h0000, 2'b11, 16'h1111, lat, rd, err, ra);
    model_apply(1'b1, 16'h0000, 2'b11, 16'h1111);
    xfer(1'b1, 1'b0, 16'h8000, 2'b00, 16'h0000, lat, rd, err, ra);
    model_apply(1'b0, 16'h8000, 2'b00, 16'h0000);
    total++;
    if (rd !== ref_rdata) begin bad++; $display("FAIL range_rd_8000 got=%h exp=%h", rd, ref_rdata); end
    total++;
    if (err !== ref_err) begin bad++; $display("FAIL range_err got=%b exp=%b", err, ref_err); end
    xfer(1'b0, 1'b1, 16'h8004, 2'b11, 16'h3333, lat, rd, err, ra);
    model_apply(1'b1, 16'h8004, 2'b11, 16'h3333);
    xfer(1'b1, 1'b0, 16'h0004, 2'b00, 16'h0000, lat, rd, err, ra);
    model_apply(1'b0, 16'h0004, 2'b00, 16'h0000);
    total++;
    if (rd !== ref_rdata) begin bad++; $display("FAIL range_alias_wr got=%h exp=%h", rd, ref_rdata); end
    total++;
    if (err !== ref_err) begin bad++; $display("FAIL range_err_sticky got=%b exp=%b", err, ref_err); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] rd; logic err; logic ra; int op;
    logic [15:0] a; logic [1:0] be; logic [15:0] wd; bit r; bit w;
    for (int i = 0; i < 8; i++) begin
      a  = 16'h0200 + 16'(2 * i);
      wd = 16'($urandom);
      xfer(1'b0, 1'b1, a, 2'b11, wd, lat, rd, err, ra);
      model_apply(1'b1, a, 2'b11, wd);
    end
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      a  = 16'h0200 + 16'(2 * $urandom_range(0, 7)) + 16'($urandom_range(0, 1));
      be = 2'($urandom);
      wd = 16'($urandom);
      r  = (op == 0 || op == 1 || op == 3);
      w  = (op == 2 || op == 3);
      xfer(r, w, a, be, wd, lat, rd, err, ra);
      model_apply(w, a, be, wd);
      total++;
      if (lat !== LAT + 1) begin bad++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, LAT + 1); end
      total++;
      if (rd !== ref_rdata) begin bad++; $display("FAIL rand_rdata[%0d] op=%0d addr=%h got=%h exp=%h", i, op, a, rd, ref_rdata); end
      total++;
      if ({err, ra} !== {ref_err, 1'b0}) begin bad++; $display("FAIL rand_err_gap[%0d] got=%b%b exp=%b0", i, err, ra, ref_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_priority();
    test_indirect();
    test_captured();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
